// File: rtl/mioc_bus_pkg.sv
// rtl/mioc_bus_pkg.sv - shared op codes and bus cycle state encoding
package mioc_bus_pkg;

    localparam logic [2:0] OP_MRD   = 3'd0;
    localparam logic [2:0] OP_MWR   = 3'd1;
    localparam logic [2:0] OP_IORD  = 3'd2;
    localparam logic [2:0] OP_IOWR  = 3'd3;
    localparam logic [2:0] OP_FETCH = 3'd4;
    localparam logic [2:0] OP_RFSH  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREQ,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_REL
    } bus_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_RFSH;
    endfunction

    function automatic logic op_is_io(input logic [2:0] op);
        return (op == OP_IORD) || (op == OP_IOWR);
    endfunction

    function automatic logic op_is_write(input logic [2:0] op);
        return (op == OP_MWR) || (op == OP_IOWR);
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_MRD) || (op == OP_IORD) || (op == OP_FETCH);
    endfunction

endpackage

// File: rtl/adam_bus_master.sv
// rtl/adam_bus_master.sv - ADAM/ColecoVision expansion-bus initiator (Z80-style cycles)
// Ports:
//   B_PHI, N_CVRST            bus clock, asynchronous active-low reset
//   req_*                     single-transaction request handshake from the client
//   rsp_*                     one-cycle completion pulse with read data / abort flag
//   BUSRQ_N, BUSAK_N          bus acquisition handshake
//   WAIT_N                    wait-state request from the addressed device
//   BA, BD_*, BUS_OE          address/data buses and driver enables
//   BMREQ_N..BM1_N            Z80 bus strobes
module adam_bus_master
    import mioc_bus_pkg::*;
#(
    parameter int unsigned BUSAK_TIMEOUT = 64,
    parameter int unsigned WAIT_MAX      = 32
) (
    input  logic        B_PHI,
    input  logic        N_CVRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        BUSRQ_N,
    input  logic        BUSAK_N,
    input  logic        WAIT_N,
    output logic [15:0] BA,
    input  logic [7:0]  BD_IN,
    output logic [7:0]  BD_OUT,
    output logic        BD_OE,
    output logic        BUS_OE,
    output logic        BMREQ_N,
    output logic        BRD_N,
    output logic        N_BWR,
    output logic        IORQ_N,
    output logic        BRFSH_N,
    output logic        BM1_N
);

    localparam logic [7:0] TO_LAST   = 8'(BUSAK_TIMEOUT - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    bus_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;          // BUSAK timeout in BREQ, wait count in TW
    logic [2:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        pend_err_q, pend_err_d;  // illegal op accepted during T3
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        busrq_n_q, busrq_n_d;
    logic [15:0] ba_q, ba_d;
    logic [7:0]  bd_out_q, bd_out_d;
    logic        bd_oe_q, bd_oe_d;
    logic        bus_oe_q, bus_oe_d;
    logic        mreq_n_q, mreq_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        iorq_n_q, iorq_n_d;
    logic        rfsh_n_q, rfsh_n_d;
    logic        m1_n_q, m1_n_d;

    logic accept;
    logic bus_own;
    logic strobe;

    assign accept = req_valid && req_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pend_err_d  = pend_err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (op_is_legal(req_op)) begin
                        state_d = ST_BREQ;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_BREQ: begin
                // Acknowledge is checked first so it wins over a same-cycle timeout.
                if (!BUSAK_N) begin
                    state_d = ST_T1;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_T1: state_d = ST_T2;
            ST_T2: begin
                // I/O cycles always get one TW regardless of WAIT_N.
                if (op_is_io(op_q) || !WAIT_N) begin
                    state_d = ST_TW;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_TW: begin
                if (WAIT_N) begin
                    state_d = ST_T3;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d     = ST_REL;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_T3: begin
                rsp_valid_d = 1'b1;
                if (op_is_read(op_q)) begin
                    rsp_rdata_d = BD_IN;
                end
                state_d = ST_REL;
                if (accept) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (op_is_legal(req_op)) begin
                        state_d = ST_T1;
                    end else begin
                        // Its error response must follow this cycle's completion.
                        pend_err_d = 1'b1;
                    end
                end
            end
            ST_REL: begin
                state_d = ST_IDLE;
                if (pend_err_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    pend_err_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every output is decoded from the next state so the pins change on the
    // same edge as the state register.
    always_comb begin
        bus_own     = (state_d == ST_T1) || (state_d == ST_T2) ||
                      (state_d == ST_TW) || (state_d == ST_T3);
        strobe      = (state_d == ST_T2) || (state_d == ST_TW) || (state_d == ST_T3);
        req_ready_d = (state_d == ST_IDLE) || (state_d == ST_T3);
        busrq_n_d   = !(bus_own || (state_d == ST_BREQ));
        bus_oe_d    = bus_own;
        ba_d        = bus_own ? addr_d : ba_q;
        bd_oe_d     = bus_own && op_is_write(op_d);
        bd_out_d    = bd_oe_d ? wdata_d : bd_out_q;
        m1_n_d      = !((op_d == OP_FETCH) && ((state_d == ST_T1) || (state_d == ST_T2)));
        mreq_n_d    = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        iorq_n_d    = 1'b1;
        rfsh_n_d    = 1'b1;
        if (strobe) begin
            case (op_d)
                OP_MRD, OP_FETCH: begin mreq_n_d = 1'b0; rd_n_d   = 1'b0; end
                OP_MWR:           begin mreq_n_d = 1'b0; wr_n_d   = 1'b0; end
                OP_IORD:          begin iorq_n_d = 1'b0; rd_n_d   = 1'b0; end
                OP_IOWR:          begin iorq_n_d = 1'b0; wr_n_d   = 1'b0; end
                OP_RFSH:          begin mreq_n_d = 1'b0; rfsh_n_d = 1'b0; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge B_PHI or negedge N_CVRST) begin
        if (!N_CVRST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MRD;
            addr_q      <= '0;
            wdata_q     <= '0;
            pend_err_q  <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busrq_n_q   <= 1'b1;
            ba_q        <= '0;
            bd_out_q    <= '0;
            bd_oe_q     <= 1'b0;
            bus_oe_q    <= 1'b0;
            mreq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            iorq_n_q    <= 1'b1;
            rfsh_n_q    <= 1'b1;
            m1_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pend_err_q  <= pend_err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busrq_n_q   <= busrq_n_d;
            ba_q        <= ba_d;
            bd_out_q    <= bd_out_d;
            bd_oe_q     <= bd_oe_d;
            bus_oe_q    <= bus_oe_d;
            mreq_n_q    <= mreq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            iorq_n_q    <= iorq_n_d;
            rfsh_n_q    <= rfsh_n_d;
            m1_n_q      <= m1_n_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign BUSRQ_N   = busrq_n_q;
    assign BA        = ba_q;
    assign BD_OUT    = bd_out_q;
    assign BD_OE     = bd_oe_q;
    assign BUS_OE    = bus_oe_q;
    assign BMREQ_N   = mreq_n_q;
    assign BRD_N     = rd_n_q;
    assign N_BWR     = wr_n_q;
    assign IORQ_N    = iorq_n_q;
    assign BRFSH_N   = rfsh_n_q;
    assign BM1_N     = m1_n_q;

endmodule
